// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Brief    : Write, read, issue and status bundle of the multi-port register file
// Revision : 1.0
// ============================================================================
interface regfile_mp_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2
);
    logic                          ready;
    logic                          wen0;
    logic [ADDR_WIDTH-1:0]         waddr0;
    logic [DATA_WIDTH-1:0]         wdata0;
    logic                          wen1;
    logic [ADDR_WIDTH-1:0]         waddr1;
    logic [DATA_WIDTH-1:0]         wdata1;
    logic [NREAD*ADDR_WIDTH-1:0]   raddr;
    logic [NREAD*DATA_WIDTH-1:0]   rdata;
    logic [NREAD-1:0]              rbusy;
    logic                          iss_valid;
    logic [ADDR_WIDTH-1:0]         iss_rd;
    logic [DATA_WIDTH-1:0]         ret_val;

    modport master (
        input  ready, rdata, rbusy, ret_val,
        output wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, iss_valid, iss_rd
    );

    modport slave (
        output ready, rdata, rbusy, ret_val,
        input  wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, iss_valid, iss_rd
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with write bypass, busy scoreboard and
//            post-reset clear sequencer
// Revision : 1.0
// ============================================================================
module regfile_mp #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2,
    parameter int BYPASS     = 1,
    parameter int RET_IDX    = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ret_idx  = ADDR_WIDTH'(RET_IDX);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
    logic [DEPTH-1:0]       busy_q, busy_d;
    logic [DATA_WIDTH-1:0]  rf_q [DEPTH];
    logic [DATA_WIDTH-1:0]  rf_d [DEPTH];

    logic w_ready;
    logic w_wr0;
    logic w_wr1;
    logic w_iss;

    // Writes and issues are qualified by READY so the clear sequence owns the array
    assign w_ready = (state_q == ST_READY);
    assign w_wr0   = w_ready && bus.wen0 && (bus.waddr0 != '0);
    assign w_wr1   = w_ready && bus.wen1 && (bus.waddr1 != '0);
    assign w_iss   = w_ready && bus.iss_valid && (bus.iss_rd != '0);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        rf_d      = rf_q;
        if (state_q == ST_CLEAR) begin
            rf_d[clr_cnt_q] = '0;
            clr_cnt_d       = clr_cnt_q + 1'b1;
            if (clr_cnt_q == c_last_idx) begin
                state_d = ST_READY;
            end
        end else begin
            if (w_wr0) begin
                rf_d[bus.waddr0]   = bus.wdata0;
                busy_d[bus.waddr0] = 1'b0;
            end
            if (w_wr1) begin
                rf_d[bus.waddr1]   = bus.wdata1;
                busy_d[bus.waddr1] = 1'b0;
            end
            // A fresh producer outranks a retiring one on the same index
            if (w_iss) begin
                busy_d[bus.iss_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= ADDR_WIDTH'(1);
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Storage has no reset; the clear sequencer initialises it
    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    logic [NREAD*DATA_WIDTH-1:0] w_rdata;
    logic [NREAD-1:0]            w_rbusy;
    logic [ADDR_WIDTH-1:0]       w_ra;
    logic [DATA_WIDTH-1:0]       w_rd;

    always_comb begin
        w_rdata = '0;
        w_rbusy = '0;
        w_ra    = '0;
        w_rd    = '0;
        for (int i = 0; i < NREAD; i++) begin
            w_ra = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_rd = rf_q[w_ra];
            if (BYPASS != 0) begin
                if (w_wr0 && (bus.waddr0 == w_ra)) w_rd = bus.wdata0;
                if (w_wr1 && (bus.waddr1 == w_ra)) w_rd = bus.wdata1;
            end
            if (!w_ready || (w_ra == '0)) begin
                w_rd = '0;
            end
            w_rdata[i*DATA_WIDTH +: DATA_WIDTH] = w_rd;
            w_rbusy[i] = w_ready && busy_q[w_ra];
        end
    end

    assign bus.ready   = w_ready;
    assign bus.rdata   = w_rdata;
    assign bus.rbusy   = w_rbusy;
    assign bus.ret_val = w_ready ? rf_q[c_ret_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed vector bench; bypass and non-bypass instances share stimulus
// Revision : 1.0
// ============================================================================
module tb_regfile_mp;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NREAD(2)) bus_b ();
    regfile_mp_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NREAD(2)) bus_n ();

    assign bus_n.wen0      = bus_b.wen0;
    assign bus_n.waddr0    = bus_b.waddr0;
    assign bus_n.wdata0    = bus_b.wdata0;
    assign bus_n.wen1      = bus_b.wen1;
    assign bus_n.waddr1    = bus_b.waddr1;
    assign bus_n.wdata1    = bus_b.wdata1;
    assign bus_n.raddr     = bus_b.raddr;
    assign bus_n.iss_valid = bus_b.iss_valid;
    assign bus_n.iss_rd    = bus_b.iss_rd;

    regfile_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NREAD(2), .BYPASS(1), .RET_IDX(10))
        u_dut_byp (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    regfile_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NREAD(2), .BYPASS(0), .RET_IDX(10))
        u_dut_nob (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    typedef struct {
        logic        w0;
        logic [3:0]  a0;
        logic [31:0] d0;
        logic        w1;
        logic [3:0]  a1;
        logic [31:0] d1;
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic        iv;
        logic [3:0]  ir;
        logic [31:0] eb0;
        logic [31:0] eb1;
        logic [31:0] en0;
        logic [31:0] en1;
        logic [1:0]  ebusy;
        logic [31:0] eret;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus_b.wen0 = 1'b0; bus_b.waddr0 = '0; bus_b.wdata0 = '0;
        bus_b.wen1 = 1'b0; bus_b.waddr1 = '0; bus_b.wdata1 = '0;
        bus_b.raddr = '0;  bus_b.iss_valid = 1'b0; bus_b.iss_rd = '0;
    endtask

    // Counts edges from reset release; ready must rise on exactly the 15th
    task automatic clear_phase(input string tag);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s ready edge %0d", tag, k), {31'd0, bus_b.ready}, {31'd0, (k == 15)});
            chk($sformatf("%s nob ready edge %0d", tag, k), {31'd0, bus_n.ready}, {31'd0, (k == 15)});
            if (k == 5) begin
                chk($sformatf("%s clear rdata0", tag), bus_b.rdata[31:0], 32'd0);
                chk($sformatf("%s clear rbusy", tag), {30'd0, bus_b.rbusy}, 32'd0);
                chk($sformatf("%s clear ret", tag), bus_b.ret_val, 32'd0);
            end
            if (k == 15) drive_idle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive_idle();

        //                w0   a0    d0            w1   a1    d1            r0    r1    iv   ir    eb0           eb1           en0           en1           busy   ret
        vt[0]  = '{1'b1, 4'd5, 32'h1234,  1'b0, 4'd0, 32'h0,     4'd5, 4'd0, 1'b0, 4'd0, 32'h1234,  32'h0,     32'h0,     32'h0,     2'b00, 32'h0};
        vt[1]  = '{1'b0, 4'd0, 32'h0,     1'b0, 4'd0, 32'h0,     4'd5, 4'd7, 1'b0, 4'd0, 32'h1234,  32'h0,     32'h1234,  32'h0,     2'b00, 32'h0};
        vt[2]  = '{1'b1, 4'd7, 32'hAAAA,  1'b1, 4'd7, 32'hBBBB,  4'd7, 4'd5, 1'b0, 4'd0, 32'hBBBB,  32'h1234,  32'h0,     32'h1234,  2'b00, 32'h0};
        vt[3]  = '{1'b0, 4'd0, 32'h0,     1'b0, 4'd0, 32'h0,     4'd7, 4'd0, 1'b0, 4'd0, 32'hBBBB,  32'h0,     32'hBBBB,  32'h0,     2'b00, 32'h0};
        vt[4]  = '{1'b1, 4'd0, 32'hDEAD,  1'b1, 4'd0, 32'hBEEF,  4'd0, 4'd0, 1'b1, 4'd0, 32'h0,     32'h0,     32'h0,     32'h0,     2'b00, 32'h0};
        vt[5]  = '{1'b0, 4'd0, 32'h0,     1'b0, 4'd0, 32'h0,     4'd3, 4'd0, 1'b1, 4'd3, 32'h0,     32'h0,     32'h0,     32'h0,     2'b00, 32'h0};
        vt[6]  = '{1'b0, 4'd0, 32'h0,     1'b1, 4'd3, 32'h33,    4'd3, 4'd0, 1'b1, 4'd3, 32'h33,    32'h0,     32'h0,     32'h0,     2'b01, 32'h0};
        vt[7]  = '{1'b0, 4'd0, 32'h0,     1'b0, 4'd0, 32'h0,     4'd3, 4'd0, 1'b0, 4'd0, 32'h33,    32'h0,     32'h33,    32'h0,     2'b01, 32'h0};
        vt[8]  = '{1'b1, 4'd3, 32'h44,    1'b0, 4'd0, 32'h0,     4'd3, 4'd3, 1'b0, 4'd0, 32'h44,    32'h44,    32'h33,    32'h33,    2'b11, 32'h0};
        vt[9]  = '{1'b0, 4'd0, 32'h0,     1'b0, 4'd0, 32'h0,     4'd3, 4'd0, 1'b0, 4'd0, 32'h44,    32'h0,     32'h44,    32'h0,     2'b00, 32'h0};
        vt[10] = '{1'b1, 4'd6, 32'h66,    1'b1, 4'd8, 32'h88,    4'd8, 4'd6, 1'b0, 4'd0, 32'h88,    32'h66,    32'h0,     32'h0,     2'b00, 32'h0};
        vt[11] = '{1'b0, 4'd0, 32'h0,     1'b0, 4'd0, 32'h0,     4'd6, 4'd8, 1'b0, 4'd0, 32'h66,    32'h88,    32'h66,    32'h88,    2'b00, 32'h0};
        vt[12] = '{1'b1, 4'd10, 32'h55,   1'b0, 4'd0, 32'h0,     4'd10, 4'd0, 1'b0, 4'd0, 32'h55,   32'h0,     32'h0,     32'h0,     2'b00, 32'h0};
        vt[13] = '{1'b0, 4'd0, 32'h0,     1'b0, 4'd0, 32'h0,     4'd10, 4'd0, 1'b1, 4'd4, 32'h55,   32'h0,     32'h55,    32'h0,     2'b00, 32'h55};
        vt[14] = '{1'b0, 4'd0, 32'h0,     1'b0, 4'd0, 32'h0,     4'd4, 4'd10, 1'b0, 4'd0, 32'h0,    32'h55,    32'h0,     32'h55,    2'b01, 32'h55};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", {31'd0, bus_b.ready}, 32'd0);
        chk("reset rdata0", bus_b.rdata[31:0], 32'd0);
        chk("reset ret", bus_n.ret_val, 32'd0);

        // Release, with write and issue traffic that the clear phase must ignore
        rst_n = 1'b1;
        bus_b.wen0 = 1'b1; bus_b.waddr0 = 4'd1; bus_b.wdata0 = 32'hFFFF;
        bus_b.wen1 = 1'b1; bus_b.waddr1 = 4'd2; bus_b.wdata1 = 32'hEEEE;
        bus_b.iss_valid = 1'b1; bus_b.iss_rd = 4'd2;
        bus_b.raddr = {4'd2, 4'd1};
        clear_phase("init");

        for (int r = 1; r < 16; r++) begin
            bus_b.raddr = {4'(r), 4'(r)};
            #2;
            chk($sformatf("cleared r%0d byp", r), bus_b.rdata[31:0], 32'd0);
            chk($sformatf("cleared r%0d nob", r), bus_n.rdata[63:32], 32'd0);
            chk($sformatf("cleared r%0d busy", r), {30'd0, bus_b.rbusy}, 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            bus_b.wen0 = vt[i].w0; bus_b.waddr0 = vt[i].a0; bus_b.wdata0 = vt[i].d0;
            bus_b.wen1 = vt[i].w1; bus_b.waddr1 = vt[i].a1; bus_b.wdata1 = vt[i].d1;
            bus_b.raddr = {vt[i].r1, vt[i].r0};
            bus_b.iss_valid = vt[i].iv; bus_b.iss_rd = vt[i].ir;
            #2;
            chk($sformatf("v%0d byp rd0", i), bus_b.rdata[31:0],  vt[i].eb0);
            chk($sformatf("v%0d byp rd1", i), bus_b.rdata[63:32], vt[i].eb1);
            chk($sformatf("v%0d nob rd0", i), bus_n.rdata[31:0],  vt[i].en0);
            chk($sformatf("v%0d nob rd1", i), bus_n.rdata[63:32], vt[i].en1);
            chk($sformatf("v%0d byp rbusy", i), {30'd0, bus_b.rbusy}, {30'd0, vt[i].ebusy});
            chk($sformatf("v%0d nob rbusy", i), {30'd0, bus_n.rbusy}, {30'd0, vt[i].ebusy});
            chk($sformatf("v%0d ret", i), bus_b.ret_val, vt[i].eret);
            chk($sformatf("v%0d nob ret", i), bus_n.ret_val, vt[i].eret);
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-READY with busy[4] set
        drive_idle();
        bus_b.raddr = {4'd10, 4'd4};
        #1;
        chk("pre-reset rbusy", {30'd0, bus_b.rbusy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async ready", {31'd0, bus_b.ready}, 32'd0);
        chk("async rbusy", {30'd0, bus_b.rbusy}, 32'd0);
        chk("async rdata1", bus_b.rdata[63:32], 32'd0);
        chk("async ret", bus_b.ret_val, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_phase("rerun");
        bus_b.raddr = {4'd10, 4'd4};
        #2;
        chk("rerun ret", bus_b.ret_val, 32'd0);
        chk("rerun rd r10", bus_b.rdata[63:32], 32'd0);
        chk("rerun rbusy r4", {30'd0, bus_b.rbusy}, 32'd0);
        bus_b.raddr = {4'd7, 4'd5};
        #2;
        chk("rerun rd r5", bus_n.rdata[31:0], 32'd0);
        chk("rerun rd r7", bus_n.rdata[63:32], 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the NPC core; successor to the single-write RV32E register file.
- Adds a configurable read-port count, two write ports with fixed priority, optional write-to-read bypass, and a per-register busy scoreboard.
- Adds a post-reset clear sequencer, so the array needs no per-entry reset.
- Sits between decode (read and issue) and writeback (write ports).

Parameters:
- ADDR_WIDTH, 4, register index width; DEPTH = 2**ADDR_WIDTH (16 for RV32E).
- DATA_WIDTH, 32, register width.
- NREAD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns the array value only.
- RET_IDX, 10, index driven on ret_val (a0).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ready  out  1  high once the clear sequence has finished.
- wen0  in  1  write enable, port 0.
- waddr0  in  ADDR_WIDTH  write index, port 0.
- wdata0  in  DATA_WIDTH  write data, port 0.
- wen1  in  1  write enable, port 1 (priority port).
- waddr1  in  ADDR_WIDTH  write index, port 1.
- wdata1  in  DATA_WIDTH  write data, port 1.
- raddr  in  NREAD*ADDR_WIDTH  packed read indices; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NREAD*DATA_WIDTH  packed read data, same slicing.
- rbusy  out  NREAD  busy bit of each read index.
- iss_valid  in  1  issue strobe; marks iss_rd pending.
- iss_rd  in  ADDR_WIDTH  destination register of the issued instruction.
- ret_val  out  DATA_WIDTH  current value of rf[RET_IDX].

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=CLEAR, clr_cnt=1, all busy bits cleared.
  - Outputs: ready=0, rdata=0, rbusy=0, ret_val=0.
  - Array contents are not reset.
- FSM states: CLEAR, READY.
- CLEAR state:
  - Each posedge writes rf[clr_cnt]=0 and increments clr_cnt.
  - When clr_cnt==DEPTH-1 is written, next state is READY.
  - ready rises after exactly DEPTH-1 posedges following rst_n release (15 for the default).
- While in CLEAR:
  - wen0, wen1 and iss_valid are ignored.
  - rdata, rbusy and ret_val are forced to 0.
- READY is terminal; only reset leaves it.
- Writes (READY only):
  - wenN && waddrN!=0 writes wdataN at posedge.
  - Both ports to the same index: port 1 wins.
  - Writes to index 0 are dropped.
- Reads are combinational:
  - raddr==0 returns 0, always.
  - With BYPASS=1, if a write to raddr is enabled this cycle (index non-zero), rdata returns that wdata, with port 1 taking priority over port 0. Otherwise rdata returns the array value.
  - With BYPASS=0, rdata returns the array value; the new value is visible the cycle after the write.
- Scoreboard (READY only):
  - iss_valid && iss_rd!=0 sets busy[iss_rd] at posedge.
  - Any enabled write to index k clears busy[k] at posedge.
  - Set and clear of the same index in the same cycle: set wins (a new producer is in flight).
  - busy[0] is always 0.
  - rbusy[i] = busy[raddr_i] as registered (no bypass of same-cycle set or clear).
- ret_val = rf[RET_IDX], registered-array value, no bypass; 0 during CLEAR.
- Reset asserted mid-operation (CLEAR or READY):
  - Immediate return to CLEAR.
  - ready drops asynchronously; busy bits cleared.
  - The clear sequence restarts from index 1.
- Widths: clr_cnt is ADDR_WIDTH bits. No arithmetic on data.

Test Plan:
1. Release rst_n, ADDR_WIDTH=4 -> ready=0 for 15 posedges and 1 after the 15th; all 15 registers read 0; writes attempted during CLEAR leave no effect.
2. READY; wen0 waddr0=5 wdata0=0x1234, with raddr port0=5 in the same cycle -> BYPASS=1: rdata0=0x1234 in that cycle. BYPASS=0: old value (0) in that cycle, 0x1234 the next cycle.
3. wen0 and wen1 both to index 7, wdata 0xAAAA and 0xBBBB -> rf[7]=0xBBBB; a bypass read of 7 in that cycle returns 0xBBBB.
4. Write 0xDEAD to index 0 -> raddr=0 returns 0; busy[0] stays 0 after iss_rd=0.
5. iss_rd=3 -> rbusy=1 for raddr=3 next cycle. Same-cycle iss_rd=3 and wen1 waddr1=3 -> busy stays 1. Later wen0 waddr0=3 alone -> rbusy=0 the next cycle.
6. Write 0x55 to index 10, check ret_val=0x55; assert rst_n low mid-READY with busy[4]=1 -> ready=0 and rbusy=0 immediately; after release the clear restarts and ret_val reads 0 once ready=1.
